// File: rtl/stream_cipher_codec_if.sv
// Stream cipher codec bus: key load, input beat and registered result.
// The source side uses the master modport and the codec uses the slave modport.
interface stream_cipher_codec_if #(
    parameter int WIDTH = 4
);
    logic             key_load;
    logic [WIDTH-1:0] key;
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             out_valid;
    logic [WIDTH-1:0] dout;

    modport master (
        output key_load, key, in_valid, din,
        input  out_valid, dout
    );

    modport slave (
        input  key_load, key, in_valid, din,
        output out_valid, dout
    );
endinterface

// File: rtl/stream_cipher_codec.sv
// XOR stream cipher codec: each accepted word is XORed with a key word and registered.
// Define KEYSTREAM_LFSR_EN to turn the key register into a Fibonacci LFSR keystream.
module stream_cipher_codec #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_cipher_codec_if.slave  bus
);
    logic [WIDTH-1:0] r_key;
    logic [WIDTH-1:0] r_dout;
    logic             r_outValid;
    logic [WIDTH-1:0] w_keyword;

`ifdef KEYSTREAM_LFSR_EN
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_nextState;

    // A zero seed would lock the LFSR up, so it is replaced by all-ones.
    always_comb begin
        w_seed      = (bus.key == '0) ? '1 : bus.key;
        w_keyword   = bus.key_load ? w_seed : r_key;
        w_nextState = {w_keyword[WIDTH-2:0], w_keyword[WIDTH-1] ^ w_keyword[WIDTH-2]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key <= '1;
        end else if (bus.in_valid) begin
            r_key <= w_nextState;
        end else if (bus.key_load) begin
            r_key <= w_seed;
        end
    end
`else
    always_comb begin
        w_keyword = bus.key_load ? bus.key : r_key;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (bus.key_load) begin
            r_key <= bus.key;
        end
    end
`endif

    // dout only moves on an accepted beat, so idle cycles leave the last result visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_dout <= bus.din ^ w_keyword;
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.out_valid = r_outValid;
endmodule

// File: tb/tb_stream_cipher_codec.sv
// Self-checking bench for stream_cipher_codec: directed steps plus random beats against a reference model.
// A second instance fed from the first checks the round trip; KEYSTREAM_LFSR_EN selects the LFSR checks.
module tb_stream_cipher_codec;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    stream_cipher_codec_if #(.WIDTH(WIDTH)) bus1 ();
    stream_cipher_codec_if #(.WIDTH(WIDTH)) bus2 ();

    stream_cipher_codec #(.WIDTH(WIDTH)) dutTx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    stream_cipher_codec #(.WIDTH(WIDTH)) dutRx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.key_load = bus1.key_load;
    assign bus2.key      = bus1.key;
    assign bus2.in_valid = bus1.out_valid;
    assign bus2.din      = bus1.dout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] refKey;
    logic [WIDTH-1:0] refDout;
    logic             refValid;
    logic             prevIv;
    logic [WIDTH-1:0] prevDin;
    logic             rtCheck;
    logic [WIDTH-1:0] obs [16];

`ifdef KEYSTREAM_LFSR_EN
    localparam bit LFSR_MODE = 1'b1;
`else
    localparam bit LFSR_MODE = 1'b0;
`endif

    // One keystream step: shift left, feed back the XOR of the two top bits.
    function automatic logic [WIDTH-1:0] lfsrStep(input logic [WIDTH-1:0] s);
        int fb;
        fb = ((s >> (WIDTH - 1)) & 1) ^ ((s >> (WIDTH - 2)) & 1);
        return WIDTH'(((s * 2) % (1 << WIDTH)) + fb);
    endfunction

    function automatic logic [WIDTH-1:0] seedOf(input logic [WIDTH-1:0] k);
        if (LFSR_MODE && k == 0) return '1;
        return k;
    endfunction

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus1.out_valid === refValid) else begin
            errors++;
            $error("FAIL %s out_valid observed=%0b expected=%0b", tag, bus1.out_valid, refValid);
        end
        checks++;
        assert (bus1.dout === refDout) else begin
            errors++;
            $error("FAIL %s dout observed=%b expected=%b", tag, bus1.dout, refDout);
        end
        if (rtCheck) begin
            checks++;
            assert (bus2.out_valid === prevIv) else begin
                errors++;
                $error("FAIL %s roundtrip valid observed=%0b expected=%0b", tag, bus2.out_valid, prevIv);
            end
            if (prevIv) begin
                checks++;
                assert (bus2.dout === prevDin) else begin
                    errors++;
                    $error("FAIL %s roundtrip dout observed=%b expected=%b", tag, bus2.dout, prevDin);
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the reference model at the edge, then check.
    task automatic applyStimulus(input logic kl, input logic [WIDTH-1:0] k, input logic iv,
                                 input logic [WIDTH-1:0] d, input logic rn, input string tag);
        logic [WIDTH-1:0] kw;
        logic             lastIv;
        logic [WIDTH-1:0] lastDin;
        bus1.key_load = kl;
        bus1.key      = k;
        bus1.in_valid = iv;
        bus1.din      = d;
        rst_n         = rn;
        @(posedge clk);
        if (!rn) begin
            refKey   = LFSR_MODE ? '1 : '0;
            refDout  = '0;
            refValid = 1'b0;
        end else begin
            kw       = kl ? seedOf(k) : refKey;
            refValid = iv;
            if (iv) refDout = d ^ kw;
            if (LFSR_MODE) begin
                if (iv) refKey = lfsrStep(kw);
                else if (kl) refKey = kw;
            end else if (kl) begin
                refKey = k;
            end
        end
        lastIv  = prevIv;
        lastDin = prevDin;
        prevIv  = iv & rn;
        prevDin = d;
        #1;
        prevIv  = lastIv;
        prevDin = lastDin;
        checkOutput(tag);
        prevIv  = iv & rn;
        prevDin = d;
    endtask

    initial begin
        rtCheck  = 1'b0;
        prevIv   = 1'b0;
        prevDin  = '0;
        refKey   = '0;
        refDout  = '0;
        refValid = 1'b0;
        bus1.key_load = 1'b0;
        bus1.key      = '0;
        bus1.in_valid = 1'b0;
        bus1.din      = '0;
        rst_n         = 1'b0;

        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, "reset0");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, "reset1");

`ifndef KEYSTREAM_LFSR_EN
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1010, 1'b1, "key0_identity");
        applyStimulus(1'b1, 4'b1110, 1'b0, 4'b0000, 1'b1, "keyload_idle");
        rtCheck = 1'b1;
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, "basic_cipher");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "rt_0000");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b1, "rt_1111");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1010, 1'b1, "rt_1010");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "rt_drain0");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "rt_drain1");
        rtCheck = 1'b0;
        applyStimulus(1'b1, 4'b0101, 1'b1, 4'b0011, 1'b1, "key_bypass");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "key_held");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0101, 1'b1, "din_eq_key");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b0, 4'b1001, 1'b1, "idle_hold");
        end
`else
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "lfsr_reset_state");
        applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, "lfsr_seed");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, "lfsr_keystream");
            obs[i] = bus1.dout;
        end
        checks++;
        assert (obs[15] === obs[0]) else begin
            errors++;
            $error("FAIL lfsr_period observed=%b expected=%b", obs[15], obs[0]);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, "lfsr_seed_zero");
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "lfsr_settle");
        applyStimulus(1'b1, 4'b1011, 1'b0, 4'b0000, 1'b1, "lfsr_rt_seed");
        rtCheck = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 4'b0000, 1'($urandom_range(0, 1)), 4'($urandom), 1'b1, "lfsr_rt");
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "lfsr_rt_drain");
        rtCheck = 1'b0;
        applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, "lfsr_idle");
`endif

        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0110, 1'b1, "pre_reset_beat");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b0111, 1'b0, "midstream_reset");
        applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1101, 1'b1, "post_reset_beat");

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                          4'($urandom), 1'($urandom_range(0, 15) != 0), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_cipher_codec.md
Name: stream_cipher_codec

Overview:
- Symmetric XOR stream cipher for WIDTH-bit words; each accepted word is XORed with a key word and registered.
- XOR is self-inverse, so one instance encrypts and a second instance with the same key decrypts.
- Cipher and decipher roles are the same RTL; the role depends only on what is applied to din.
- Sits between the message source and the link, with a mirror instance at the receiver.

Parameters:
- WIDTH, 4, message/key/data word width in bits (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- key_load  input  1  load key into the internal key register this cycle.
- key  input  WIDTH  key word; bit 0 is LSB.
- in_valid  input  1  din holds a word to process this cycle.
- din  input  WIDTH  plaintext (cipher role) or ciphertext (decipher role).
- out_valid  output  1  dout holds a processed word.
- dout  output  WIDTH  registered result din XOR keyword.

Behaviour:
- Reset (rst_n=0 at a rising edge): dout=0, out_valid=0, key register=0; overrides all other inputs in that cycle.
- Key register: on key_load=1, key_reg <= key.
- Effective key for the current cycle (keyword): key when key_load=1 (same-cycle bypass), otherwise key_reg.
- Beat accepted when in_valid=1 and rst_n=1; dout <= din ^ keyword, out_valid <= 1.
- Latency is exactly 1 clock from acceptance to out_valid/dout.
- No backpressure; every valid beat is accepted.
- in_valid=0: out_valid <= 0; dout holds its last value.
- Back-to-back beats: one result per clock, no bubbles.
- key_load without in_valid: only key_reg changes; outputs follow the in_valid=0 rule.
- Key changes never affect a result already registered.
- Round trip: chaining two instances with the same key reproduces din at the second dout after 2 clocks.
- Identity cases:
  - key=0 gives dout=din.
  - din=key gives dout=0.
- Reset mid-stream: a beat presented in the reset cycle is dropped; key_reg must be reloaded before further use.

Optional Feature:
- Macro: KEYSTREAM_LFSR_EN.
- Defined:
  - key_reg becomes a Fibonacci LFSR.
  - key_load seeds it with key; a seed of 0 is replaced by all-ones.
  - keyword is the current LFSR state, or the seed in a key_load cycle.
  - Each accepted beat XORs with keyword, then the LFSR advances one step: state <= {state[WIDTH-2:0], state[WIDTH-1]^state[WIDTH-2]}.
  - For WIDTH=4 this is x^4+x^3+1, period 15.
  - key_load in the same cycle as a beat: the seed is used for that beat, then advanced once.
  - Reset state: all-ones.
  - Two instances stay in lockstep when fed identical key_load/in_valid sequences.
- Not defined: static-key behaviour above, and key_reg never changes except on key_load/reset.

Test Plan:
- Reset: hold rst_n=0 two clocks with in_valid=1, din=4'b1111 -> out_valid=0, dout=4'b0000; after release, the first beat with key=0 gives dout=din.
- Basic cipher: key_load=1, key=4'b1110; next cycle in_valid=1, din=4'b1000 -> one clock later out_valid=1, dout=4'b0110.
- Round trip: cipher dout feeds a second instance keyed 4'b1110 -> second dout=4'b1000 two clocks after the first acceptance; streaming 4'b0000, 4'b1111, 4'b1010 back-to-back returns the same words in order, one per clock.
- Key bypass/change: in_valid=1, din=4'b0011, key_load=1, key=4'b0101 in the same cycle -> dout=4'b0110; the next beat with key_load=0 and din=4'b0000 -> dout=4'b0101.
- Idle hold: after a beat, drive in_valid=0 for 3 clocks -> out_valid=0, dout unchanged; assert rst_n=0 mid-stream -> outputs clear next edge.
- KEYSTREAM_LFSR_EN: seed 4'b0001, feed din=0 for 16 beats -> dout sequence repeats with period 15; seed 0 behaves like seed 4'b1111; round trip through two instances recovers the plaintext.
